ext_mem_responder: RTL and testbench

//  Responder (memory side) of the external-memory request bus driven by the system memory controller.

---
 rtl/ext_mem_responder.sv | 168 ++++++++++++++++
 tb/tb_ext_mem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_responder.sv
// Memory-side responder for the external-memory request bus.
// Serves single-word and block reads/writes from an on-chip word RAM,
// with separate programmable read and write access latencies.
module ext_mem_responder #(
    parameter int unsigned BW_BYTE_ADDR   = 26,
    parameter int unsigned MEM_DEPTH_LOG2 = 12,
    parameter int unsigned BLOCK_WORDS    = 4,
    parameter int unsigned READ_LATENCY   = 3,
    parameter int unsigned WRITE_LATENCY  = 1
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    req_i,
    input  logic                    reqBlock_i,
    input  logic                    rw_i,
    input  logic                    clear_i,
    input  logic [31:0]             data_i,
    input  logic [BW_BYTE_ADDR-1:0] add_i,
    output logic [31:0]             data_o,
    output logic                    ready_o,
    output logic                    done_o,
    output logic                    valid_o
);

    localparam int unsigned AW      = MEM_DEPTH_LOG2;
    localparam int unsigned DEPTH   = 1 << AW;
    localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int unsigned LCW     = $clog2(MAX_LAT + 1);
    localparam int unsigned BLW     = $clog2(BLOCK_WORDS);
    localparam int unsigned WCW     = BLW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAT,
        ST_XFER,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [LCW-1:0]   lat_cnt_q, lat_cnt_d;
    logic [WCW-1:0]   word_cnt_q, word_cnt_d;
    logic [AW-1:0]    base_q, base_d;
    logic             wr_q, wr_d;
    logic             blk_q, blk_d;
    logic             ready_d, valid_d, done_d;

    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic             we;
    logic [AW-1:0]    cur_addr;
    logic [AW-1:0]    req_idx;
    logic             lat_last;
    logic             word_last;
    logic             unused_addr_bits;

    logic [31:0]      mem [DEPTH];

    // Byte address bits outside the RAM index are deliberately ignored (aliasing).
    generate
        if (BW_BYTE_ADDR > AW + 2) begin : g_upper
            assign unused_addr_bits = ^{add_i[BW_BYTE_ADDR-1:AW+2], add_i[1:0]};
        end else begin : g_no_upper
            assign unused_addr_bits = ^add_i[1:0];
        end
    endgenerate

    assign req_idx   = add_i[AW+1:2];
    assign cur_addr  = base_q + AW'(word_cnt_q);
    assign lat_last  = (lat_cnt_q == (wr_q ? LCW'(WRITE_LATENCY - 1) : LCW'(READ_LATENCY - 1)));
    assign word_last = (word_cnt_q == (blk_q ? WCW'(BLOCK_WORDS - 1) : WCW'(0)));

    // State, counters, request context and registered outputs.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= ST_IDLE;
            lat_cnt_q  <= '0;
            word_cnt_q <= '0;
            base_q     <= '0;
            wr_q       <= 1'b0;
            blk_q      <= 1'b0;
            ready_o    <= 1'b0;
            valid_o    <= 1'b0;
            done_o     <= 1'b0;
            data_o     <= '0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            word_cnt_q <= word_cnt_d;
            base_q     <= base_d;
            wr_q       <= wr_d;
            blk_q      <= blk_d;
            ready_o    <= ready_d;
            valid_o    <= valid_d;
            done_o     <= done_d;
            if (rd_en) begin
                data_o <= mem[rd_addr];
            end
        end
    end

    // Next-state, counter and RAM-port decode; outputs follow the next state.
    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        word_cnt_d = word_cnt_q;
        base_d     = base_q;
        wr_d       = wr_q;
        blk_d      = blk_q;
        rd_en      = 1'b0;
        rd_addr    = cur_addr;
        we         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ready_o && req_i && !clear_i) begin
                    state_d    = ST_LAT;
                    lat_cnt_d  = '0;
                    word_cnt_d = '0;
                    wr_d       = rw_i;
                    blk_d      = reqBlock_i;
                    base_d     = reqBlock_i ? {req_idx[AW-1:BLW], BLW'(0)} : req_idx;
                end
            end
            ST_LAT: begin
                if (clear_i) begin
                    state_d = ST_IDLE;
                end else if (lat_last) begin
                    state_d = ST_XFER;
                    rd_en   = !wr_q;
                    rd_addr = base_q;
                end else begin
                    lat_cnt_d = lat_cnt_q + LCW'(1);
                end
            end
            ST_XFER: begin
                // A word presented in a valid cycle is consumed even if aborted at its closing edge.
                we = wr_q;
                if (clear_i) begin
                    state_d = ST_IDLE;
                end else if (word_last) begin
                    state_d = ST_DONE;
                end else begin
                    word_cnt_d = word_cnt_q + WCW'(1);
                    rd_en      = !wr_q;
                    rd_addr    = cur_addr + AW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_XFER);
        done_d  = (state_d == ST_DONE);
    end

    // Word RAM write port; contents survive reset.
    always_ff @(posedge clock_i) begin
        if (we) begin
            mem[cur_addr] <= data_i;
        end
    end

endmodule

// File: tb/tb_ext_mem_responder.sv
// Scoreboard bench for ext_mem_responder: stimulus queues expected
// valid/done events, a negedge monitor pops and compares them.
module tb_ext_mem_responder;

    logic        clock_i;
    logic        reset_i;
    logic        req_i;
    logic        reqBlock_i;
    logic        rw_i;
    logic        clear_i;
    logic [31:0] data_i;
    logic [25:0] add_i;
    logic [31:0] data_o;
    logic        ready_o;
    logic        done_o;
    logic        valid_o;

    ext_mem_responder dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .req_i      (req_i),
        .reqBlock_i (reqBlock_i),
        .rw_i       (rw_i),
        .clear_i    (clear_i),
        .data_i     (data_i),
        .add_i      (add_i),
        .data_o     (data_o),
        .ready_o    (ready_o),
        .done_o     (done_o),
        .valid_o    (valid_o)
    );

    typedef struct {
        int          cyc;
        bit          is_done;
        bit          chk;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] model [4096];
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    always @(posedge clock_i) cyc <= cyc + 1;

    // Monitor: every valid/done cycle must match the next queued expectation.
    always @(negedge clock_i) begin
        ev_t e;
        if (reset_i === 1'b1 && (valid_o === 1'b1 || done_o === 1'b1)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: cyc=%0d valid=%b done=%b data=%h, required no event",
                         cyc, valid_o, done_o, data_o);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.is_done != done_o || e.is_done == valid_o ||
                    (e.chk && data_o !== e.data)) begin
                    bad++;
                    $display("FAIL event: got cyc=%0d valid=%b done=%b data=%h, required cyc=%0d done=%b data=%h",
                             cyc, valid_o, done_o, data_o, e.cyc, e.is_done, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clock_i);
        while (ready_o !== 1'b1 && n < 50) begin
            @(negedge clock_i);
            n++;
        end
        if (ready_o !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: ready_o=%b required 1 within 50 cycles", ready_o);
        end
    endtask

    task automatic push_ev(input int c, input bit d, input bit chk, input logic [31:0] v);
        ev_t e;
        e.cyc = c; e.is_done = d; e.chk = chk; e.data = v;
        exp_q.push_back(e);
    endtask

    // One transaction; clear_at = spec cycle whose closing edge sees clear_i (0: none).
    task automatic xact(input bit wr, input bit blk, input logic [25:0] add,
                        input logic [3:0][31:0] wd, input int clear_at, input bit pulse_req);
        int L, N, acc, last, k;
        logic [11:0] base;
        L = wr ? 1 : 3;
        N = blk ? 4 : 1;
        base = add[13:2];
        if (blk) base[1:0] = 2'b00;
        wait_ready();
        req_i = 1'b1; rw_i = wr; reqBlock_i = blk; add_i = add; data_i = wd[0];
        @(posedge clock_i); #1;
        acc = cyc;
        req_i = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (clear_at == 0 || L + 1 + j <= clear_at) begin
                push_ev(acc + L + j, 1'b0, !wr, wr ? 32'h0 : model[base + 12'(j)]);
                if (wr) model[base + 12'(j)] = wd[j];
            end
        end
        if (clear_at == 0) push_ev(acc + L + N, 1'b1, 1'b0, 32'h0);
        last = (clear_at != 0) ? clear_at : L + N + 1;
        for (int c = 1; c <= last; c++) begin
            k = c - L - 1;
            if (k < 0) k = 0;
            if (k > N - 1) k = N - 1;
            data_i  = wd[k];
            clear_i = (c == clear_at);
            req_i   = pulse_req && (c == 2 || c == L + 2);
            if (c == 1) check("ready_low_after_accept", 32'(ready_o), 32'h0);
            @(posedge clock_i); #1;
        end
        clear_i = 1'b0;
        req_i   = 1'b0;
        check("ready_after_xact", 32'(ready_o), 32'h1);
        check("valid_after_xact", 32'(valid_o), 32'h0);
        check("done_after_xact", 32'(done_o), 32'h0);
    endtask

    initial begin
        int acc;
        int n;
        reset_i = 1'b1; req_i = 1'b0; reqBlock_i = 1'b0; rw_i = 1'b0;
        clear_i = 1'b0; data_i = 32'h0; add_i = 26'h0;

        // Reset state and first-edge ready.
        #2 reset_i = 1'b0;
        repeat (3) @(posedge clock_i);
        #1;
        check("reset_ready", 32'(ready_o), 32'h0);
        check("reset_valid", 32'(valid_o), 32'h0);
        check("reset_done", 32'(done_o), 32'h0);
        check("reset_data", data_o, 32'h0);
        #1 reset_i = 1'b1;
        #1 check("ready_before_edge", 32'(ready_o), 32'h0);
        @(posedge clock_i); #1;
        check("ready_first_edge", 32'(ready_o), 32'h1);

        // 1: single write then single read.
        xact(1'b1, 1'b0, 26'h40, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, 0, 1'b0);
        xact(1'b0, 1'b0, 26'h40, '0, 0, 1'b0);

        // 2: block write at unaligned address, block read at aligned base.
        xact(1'b1, 1'b1, 26'h10C, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 1'b0);
        xact(1'b0, 1'b1, 26'h100, '0, 0, 1'b0);

        // 3: clear during second valid cycle, then a normal single read.
        xact(1'b0, 1'b1, 26'h100, '0, 5, 1'b0);
        xact(1'b0, 1'b0, 26'h104, '0, 0, 1'b0);

        // 4: req pulses while busy are ignored; req+clear in IDLE is not accepted.
        xact(1'b0, 1'b1, 26'h100, '0, 0, 1'b1);
        wait_ready();
        req_i = 1'b1; clear_i = 1'b1; rw_i = 1'b0; reqBlock_i = 1'b0; add_i = 26'h40;
        @(posedge clock_i); #1;
        req_i = 1'b0; clear_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("idle_ready_held", 32'(ready_o), 32'h1);
            @(posedge clock_i); #1;
        end

        // 5: address aliasing above the RAM depth.
        xact(1'b1, 1'b0, 26'h4000, {32'h0, 32'h0, 32'h0, 32'hCAFEF00D}, 0, 1'b0);
        xact(1'b0, 1'b0, 26'h0, '0, 0, 1'b0);

        // 6: async reset in the middle of a block write.
        xact(1'b1, 1'b1, 26'h200, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0, 1'b0);
        wait_ready();
        req_i = 1'b1; rw_i = 1'b1; reqBlock_i = 1'b1; add_i = 26'h200; data_i = 32'hB0;
        @(posedge clock_i); #1;
        acc = cyc;
        req_i = 1'b0;
        push_ev(acc + 1, 1'b0, 1'b0, 32'h0);
        push_ev(acc + 2, 1'b0, 1'b0, 32'h0);
        model[12'h080] = 32'hB0;
        model[12'h081] = 32'hB1;
        @(posedge clock_i); #1; data_i = 32'hB0;
        @(posedge clock_i); #1; data_i = 32'hB1;
        @(posedge clock_i); #1; data_i = 32'hB2;
        #2 reset_i = 1'b0;
        #1;
        check("rst_mid_ready", 32'(ready_o), 32'h0);
        check("rst_mid_valid", 32'(valid_o), 32'h0);
        check("rst_mid_done", 32'(done_o), 32'h0);
        check("rst_mid_pending", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        repeat (2) @(negedge clock_i);
        @(posedge clock_i); #2;
        reset_i = 1'b1;
        #1 check("rst_rel_ready_low", 32'(ready_o), 32'h0);
        @(posedge clock_i); #1;
        check("rst_rel_ready_edge", 32'(ready_o), 32'h1);
        xact(1'b0, 1'b1, 26'h200, '0, 0, 1'b0);

        // Drain any outstanding expectations.
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clock_i);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d events still pending, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
